// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-Stream word type, limiter state encoding and counter helper.
// Struct fields are sized for the widest supported bus; narrower users zero-pad.
package axi4_stream_pkg;

    localparam int AXIS_MAX_TDATA_W = 512;
    localparam int AXIS_MAX_TKEEP_W = AXIS_MAX_TDATA_W / 8;
    localparam int AXIS_MAX_TUSER_W = 32;
    localparam int AXIS_MAX_TDEST_W = 16;
    localparam int AXIS_MAX_TID_W   = 16;

    typedef struct packed {
        logic [AXIS_MAX_TDATA_W-1:0] tdata;
        logic [AXIS_MAX_TKEEP_W-1:0] tstrb;
        logic [AXIS_MAX_TKEEP_W-1:0] tkeep;
        logic                        tlast;
        logic [AXIS_MAX_TUSER_W-1:0] tuser;
        logic [AXIS_MAX_TDEST_W-1:0] tdest;
        logic [AXIS_MAX_TID_W-1:0]   tid;
    } axi4_stream_word_t;

    typedef enum logic {
        LIM_PASS    = 1'b0,
        LIM_DISCARD = 1'b1
    } lim_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views; widths set per instance.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TID_WIDTH-1:0]     tid;
    logic                     tvalid;
    logic                     tready;

    modport master (
        output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
        output tready
    );
endinterface

// File: rtl/axi4_stream_reg_slice.sv
// Single-entry forward register slice, one cycle latency; accepts a new word
// whenever the slot is empty or being drained this cycle, otherwise holds.
module axi4_stream_reg_slice
    import axi4_stream_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_vld,
    output logic              in_rdy,
    input  axi4_stream_word_t in_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output axi4_stream_word_t out_dat
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vld <= 1'b0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
        end
    end

    // Payload is qualified by out_vld, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (in_vld && in_rdy) begin
            out_dat <= in_dat;
        end
    end

endmodule

// File: rtl/axi4_stream_pkt_limiter.sv
// Caps packets at MAX_PKT_WORDS words (tlast forced, tail dropped), 1-cycle latency.
// Saturating statistics only when AXI4_STREAM_PKT_LIMITER_STATS_EN is defined.
module axi4_stream_pkt_limiter
    import axi4_stream_pkg::*;
#(
    parameter int TDATA_WIDTH   = 32,
    parameter int TUSER_WIDTH   = 1,
    parameter int TDEST_WIDTH   = 1,
    parameter int TID_WIDTH     = 1,
    parameter int MAX_PKT_WORDS = 256,
    parameter int CNT_WIDTH     = $clog2(MAX_PKT_WORDS + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o,
    output logic         trunc_o,
    output logic         discard_o,
    output logic [31:0]  pkt_cnt_o,
    output logic [31:0]  trunc_cnt_o
);

    localparam int KEEP_W = TDATA_WIDTH / 8;

    lim_state_t           state;
    lim_state_t           state_nxt;
    logic [CNT_WIDTH-1:0] word_cnt;
    logic [CNT_WIDTH-1:0] word_cnt_nxt;

    logic              slice_in_rdy;
    logic              slice_out_vld;
    logic              accept;
    logic              at_limit;
    logic              trunc_hit;
    axi4_stream_word_t in_word;
    axi4_stream_word_t out_word;
    logic              unused_pad;

    // word_cnt holds words already accepted, so the current word is number word_cnt+1.
    assign at_limit  = (word_cnt == CNT_WIDTH'(MAX_PKT_WORDS - 1));
    assign pkt_i.tready = (state == LIM_DISCARD) ? 1'b1 : slice_in_rdy;
    assign accept    = pkt_i.tvalid && pkt_i.tready;
    assign trunc_hit = accept && (state == LIM_PASS) && at_limit && !pkt_i.tlast;
    assign trunc_o   = trunc_hit && !rst_i;
    assign discard_o = (state == LIM_DISCARD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= LIM_PASS;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        case (state)
            LIM_PASS: begin
                if (accept) begin
                    if (pkt_i.tlast) begin
                        word_cnt_nxt = '0;
                    end else if (at_limit) begin
                        word_cnt_nxt = '0;
                        state_nxt    = LIM_DISCARD;
                    end else begin
                        word_cnt_nxt = word_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            LIM_DISCARD: begin
                if (accept && pkt_i.tlast) begin
                    state_nxt = LIM_PASS;
                end
            end
            default: begin
                state_nxt    = LIM_PASS;
                word_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        in_word                        = '0;
        in_word.tdata[TDATA_WIDTH-1:0] = pkt_i.tdata;
        in_word.tstrb[KEEP_W-1:0]      = pkt_i.tstrb;
        in_word.tkeep[KEEP_W-1:0]      = pkt_i.tkeep;
        in_word.tlast                  = pkt_i.tlast || trunc_hit;
        in_word.tuser[TUSER_WIDTH-1:0] = pkt_i.tuser;
        in_word.tdest[TDEST_WIDTH-1:0] = pkt_i.tdest;
        in_word.tid[TID_WIDTH-1:0]     = pkt_i.tid;
    end

    // Dropped words never reach the slice; a word already held completes normally.
    axi4_stream_reg_slice u_out_slice (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_vld  (pkt_i.tvalid && (state == LIM_PASS)),
        .in_rdy  (slice_in_rdy),
        .in_dat  (in_word),
        .out_vld (slice_out_vld),
        .out_rdy (pkt_o.tready),
        .out_dat (out_word)
    );

    assign pkt_o.tvalid = slice_out_vld;
    assign pkt_o.tdata  = out_word.tdata[TDATA_WIDTH-1:0];
    assign pkt_o.tstrb  = out_word.tstrb[KEEP_W-1:0];
    assign pkt_o.tkeep  = out_word.tkeep[KEEP_W-1:0];
    assign pkt_o.tlast  = out_word.tlast;
    assign pkt_o.tuser  = out_word.tuser[TUSER_WIDTH-1:0];
    assign pkt_o.tdest  = out_word.tdest[TDEST_WIDTH-1:0];
    assign pkt_o.tid    = out_word.tid[TID_WIDTH-1:0];

    // Pad bits above the configured widths are constant zero.
    assign unused_pad = ^out_word;

`ifdef AXI4_STREAM_PKT_LIMITER_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_cnt_o   <= '0;
            trunc_cnt_o <= '0;
        end else begin
            if (slice_out_vld && pkt_o.tready && pkt_o.tlast) begin
                pkt_cnt_o <= sat_inc32(pkt_cnt_o);
            end
            if (trunc_hit) begin
                trunc_cnt_o <= sat_inc32(trunc_cnt_o);
            end
        end
    end
`else
    assign pkt_cnt_o   = '0;
    assign trunc_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi4_stream_pkt_limiter.sv
// Directed and random packets through the limiter (MAX_PKT_WORDS=4), compared
// against a packet-level model of the truncation rules.
module tb_axi4_stream_pkt_limiter;

    localparam int MAX = 4;
`ifdef AXI4_STREAM_PKT_LIMITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  k;
        logic        l;
        logic        u;
        logic        de;
        logic        i;
    } wd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trunc;
    logic        discard;
    logic [31:0] pkt_cnt;
    logic [31:0] trunc_cnt;

    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)) in_if ();
    axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)) out_if ();

    axi4_stream_pkt_limiter #(
        .TDATA_WIDTH   (32),
        .TUSER_WIDTH   (1),
        .TDEST_WIDTH   (1),
        .TID_WIDTH     (1),
        .MAX_PKT_WORDS (MAX)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pkt_i       (in_if),
        .pkt_o       (out_if),
        .trunc_o     (trunc),
        .discard_o   (discard),
        .pkt_cnt_o   (pkt_cnt),
        .trunc_cnt_o (trunc_cnt)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] stat(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    function automatic wd_t cur_out();
        wd_t w;
        w.d  = out_if.tdata;
        w.s  = out_if.tstrb;
        w.k  = out_if.tkeep;
        w.l  = out_if.tlast;
        w.u  = out_if.tuser[0];
        w.de = out_if.tdest[0];
        w.i  = out_if.tid[0];
        return w;
    endfunction

    // ---------------- monitor (sole writer of observed history) ----------------
    int  cyc = 0;
    wd_t out_q[$];
    int  out_cyc_q[$];
    int  in_cyc_q[$];
    int  trunc_seen = 0;
    int  drop_seen = 0;
    int  drop_rdy_bad = 0;
    int  last_drop_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_if.tvalid && out_if.tready) begin
                out_q.push_back(cur_out());
                out_cyc_q.push_back(cyc);
            end
            if (in_if.tvalid && in_if.tready) begin
                if (discard) begin
                    drop_seen++;
                    if (in_if.tlast) last_drop_cyc = cyc;
                end else begin
                    in_cyc_q.push_back(cyc);
                end
            end
            if (trunc) trunc_seen++;
            if (discard && !in_if.tready) drop_rdy_bad++;
        end
    end

    // ---------------- sink ready generator ----------------
    int rdy_mode = 0;
    bit rdy_force = 1'b1;

    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_if.tready = 1'b1;
                1:       out_if.tready = ($urandom_range(0, 3) != 0);
                default: out_if.tready = rdy_force;
            endcase
        end
    end

    // ---------------- reference model and driver ----------------
    wd_t exp_q[$];
    int  exp_pkts = 0;
    int  exp_trunc = 0;
    int  cmp_idx = 0;
    int  tmo = 0;

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input wd_t w);
        bit ok = 1'b0;
        in_if.tvalid = 1'b1;
        in_if.tdata  = w.d;
        in_if.tstrb  = w.s;
        in_if.tkeep  = w.k;
        in_if.tlast  = w.l;
        in_if.tuser  = w.u;
        in_if.tdest  = w.de;
        in_if.tid    = w.i;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_if.tready;
            sync();
        end
        if (!ok) tmo++;
    endtask

    // Sends the first n_send words of a len-word packet; the model keeps at most
    // MAX words, with tlast on the packet's own end or on word MAX.
    task automatic send_pkt(input int len, input int n_send, input int gap_max);
        wd_t w;
        wd_t wm;
        for (int i = 0; i < n_send; i++) begin
            w.d  = $urandom;
            w.s  = 4'($urandom);
            w.k  = 4'($urandom);
            w.u  = 1'($urandom);
            w.de = 1'($urandom);
            w.i  = 1'($urandom);
            w.l  = (i == len - 1);
            if (i < MAX) begin
                wm   = w;
                wm.l = w.l || (i == MAX - 1);
                exp_q.push_back(wm);
            end
            drive_word(w);
            if (gap_max > 0) begin
                in_if.tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) sync();
            end
        end
        if (n_send == len || n_send >= MAX) exp_pkts++;
        if (len > MAX && n_send >= MAX) exp_trunc++;
    endtask

    task automatic drain_and_compare(input string tag);
        in_if.tvalid = 1'b0;
        for (int t = 0; t < 400 && out_q.size() < exp_q.size(); t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = cmp_idx; i < exp_q.size(); i++) begin
            if (i < out_q.size()) check({tag, "_word"}, 64'(out_q[i]), 64'(exp_q[i]));
        end
        cmp_idx = exp_q.size();
        sync();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ts;
        int ib;
        int ob;
        int ds;
        wd_t snap;

        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tstrb  = '0;
        in_if.tkeep  = '0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = '0;
        in_if.tdest  = '0;
        in_if.tid    = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
        check("rst_discard", 64'(discard), 64'd0);
        check("rst_trunc", 64'(trunc), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_trunc_cnt", 64'(trunc_cnt), 64'd0);
        check("rst_in_tready", 64'(in_if.tready), 64'd1);
        sync();
        rst = 1'b0;
        sync();

        // 3-word packet, under the limit
        ts = trunc_seen; ib = in_cyc_q.size(); ob = out_cyc_q.size();
        send_pkt(3, 3, 0);
        drain_and_compare("p3");
        for (int k = 0; k < 3; k++) begin
            if (ob + k < out_cyc_q.size() && ib + k < in_cyc_q.size())
                check("p3_latency", 64'(out_cyc_q[ob + k] - in_cyc_q[ib + k]), 64'd1);
        end
        check("p3_trunc", 64'(trunc_seen - ts), 64'd0);
        check("p3_pkt_cnt", 64'(pkt_cnt), stat(exp_pkts));

        // exactly MAX words with tlast on the last
        ts = trunc_seen; ds = drop_seen;
        send_pkt(4, 4, 0);
        drain_and_compare("p4");
        check("p4_trunc", 64'(trunc_seen - ts), 64'd0);
        check("p4_drop", 64'(drop_seen - ds), 64'd0);
        check("p4_discard", 64'(discard), 64'd0);

        // 7-word packet: truncated to 4, words 5-7 dropped
        ts = trunc_seen; ds = drop_seen;
        send_pkt(7, 7, 0);
        drain_and_compare("p7");
        check("p7_trunc_pulse", 64'(trunc_seen - ts), 64'd1);
        check("p7_dropped", 64'(drop_seen - ds), 64'd3);
        check("p7_drop_rdy", 64'(drop_rdy_bad), 64'd0);
        check("p7_trunc_cnt", 64'(trunc_cnt), stat(exp_trunc));
        check("p7_back_to_pass", 64'(discard), 64'd0);

        // truncated packet followed back-to-back by a 2-word packet
        ob = out_cyc_q.size();
        send_pkt(7, 7, 0);
        send_pkt(2, 2, 0);
        drain_and_compare("p7p2");
        if (ob + 4 < out_cyc_q.size())
            check("p2_after_discard", 64'(out_cyc_q[ob + 4]), 64'(last_drop_cyc + 2));
        else
            check("p2_after_discard_present", 64'(out_cyc_q.size()), 64'(ob + 5));

        // sink stalls 3 cycles mid-packet
        ob = out_q.size();
        fork
            send_pkt(4, 4, 0);
            begin
                for (int t = 0; t < 100 && out_q.size() < ob + 1; t++) begin
                    @(negedge clk);
                    #1;
                end
                check("stall_start", 64'(out_q.size() >= ob + 1), 64'd1);
                rdy_force = 1'b0;
                rdy_mode  = 2;
                @(posedge clk);
                #2;
                snap = cur_out();
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_hold", {out_if.tvalid, 19'd0, cur_out()}, {1'b1, 19'd0, snap});
                    check("stall_in_tready", 64'(in_if.tready), 64'd0);
                end
                rdy_mode = 0;
            end
        join
        drain_and_compare("stall");
        check("stall_pkt_cnt", 64'(pkt_cnt), stat(exp_pkts));

        // reset while in DISCARD
        send_pkt(7, 5, 0);
        drain_and_compare("prerst");
        check("prerst_discard", 64'(discard), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_tvalid", 64'(out_if.tvalid), 64'd0);
        check("midrst_discard", 64'(discard), 64'd0);
        check("midrst_trunc", 64'(trunc), 64'd0);
        check("midrst_cnts", {pkt_cnt, trunc_cnt}, 64'd0);
        exp_pkts  = 0;
        exp_trunc = 0;
        sync();
        rst = 1'b0;
        sync();
        send_pkt(2, 2, 0);
        drain_and_compare("postrst");
        check("postrst_pkt_cnt", 64'(pkt_cnt), stat(exp_pkts));

        // random packets, gaps and sink backpressure
        ts = trunc_seen;
        ds = exp_trunc;
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 9);
            send_pkt(len, len, 2);
        end
        drain_and_compare("rand");
        rdy_mode = 0;
        check("rand_trunc_pulses", 64'(trunc_seen - ts), 64'(exp_trunc - ds));
        check("rand_pkt_cnt", 64'(pkt_cnt), stat(exp_pkts));
        check("rand_trunc_cnt", 64'(trunc_cnt), stat(exp_trunc));
        check("drop_rdy_total", 64'(drop_rdy_bad), 64'd0);
        check("timeouts", 64'(tmo), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
